// File: rtl/imem_loader_if.sv
// Bundle of the loader's control, upstream FIFO and instruction-memory
// write signals. The loader itself connects through the slave modport;
// whatever drives the loader (a system top or a bench) uses master.
interface imem_loader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8
);
  logic                  start;
  logic [6:0]            len;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic [BYTE_WIDTH-1:0] dir;
  logic                  we;
  logic                  busy;
  logic                  done;
  logic                  cpu_hold;

  modport slave (
    input  start, len, fifo_empty, fifo_rdata,
    output fifo_rd_en, data_in, dir, we, busy, done, cpu_hold
  );

  modport master (
    output start, len, fifo_empty, fifo_rdata,
    input  fifo_rd_en, data_in, dir, we, busy, done, cpu_hold
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: after a start request it pops len words from
// an upstream FIFO and writes them to consecutive word addresses of the
// instruction memory, holding the processor stalled while it works.
// Each word costs three cycles (pop request, data capture, write), and a
// load larger than the memory is clipped to its word capacity.
module imem_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int MEM_DEPTH  = 256
) (
  input  logic          clk,
  input  logic          rst_n,
  imem_loader_if.slave  bus
);

  localparam logic [6:0] MAX_WORDS = 7'(MEM_DEPTH / 4);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    WRITE,
    DONE
  } state_t;

  state_t                state_q, state_d;
  logic [6:0]            len_q, len_d;
  logic [6:0]            cnt_q, cnt_d;
  logic [BYTE_WIDTH-1:0] addr_q, addr_d;
  logic [BYTE_WIDTH-1:0] dir_q, dir_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  // State and datapath registers; reset returns everything to an idle, zeroed loader.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      dir_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      dir_q   <= dir_d;
      data_q  <= data_d;
    end
  end

  // Next-state logic; the write address and word are copied into output registers on entry to WRITE so they persist afterwards.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    dir_d   = dir_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.len == 7'd0) begin
            state_d = DONE;
          end else begin
            state_d = REQ;
            len_d   = (bus.len > MAX_WORDS) ? MAX_WORDS : bus.len;
            cnt_d   = '0;
            addr_d  = '0;
          end
        end
      end
      REQ: begin
        if (!bus.fifo_empty) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        data_d  = bus.fifo_rdata;
        dir_d   = addr_q;
        state_d = WRITE;
      end
      WRITE: begin
        addr_d = addr_q + BYTE_WIDTH'(4);
        cnt_d  = cnt_q + 7'd1;
        if ((cnt_q + 7'd1) == len_q) begin
          state_d = DONE;
        end else begin
          state_d = REQ;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.fifo_rd_en = (state_q == REQ) && !bus.fifo_empty;
  assign bus.we         = (state_q == WRITE);
  assign bus.dir        = dir_q;
  assign bus.data_in    = data_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.cpu_hold   = (state_q != IDLE);
  assign bus.done       = (state_q == DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: a small FIFO model feeds the loader, expected
// memory writes go into a scoreboard queue and a monitor compares every
// write the loader performs against it.
module tb_imem_loader;

  typedef struct {
    logic [7:0]  dir;
    logic [31:0] data;
  } wr_t;

  logic clk;
  logic rst_n;
  logic force_empty;
  logic flush;
  int   total;
  int   bad;
  int   wr_ptr;
  int   rd_ptr;
  logic [31:0] fifo_mem [0:255];
  wr_t  exp_q[$];

  imem_loader_if #(.DATA_WIDTH(32), .BYTE_WIDTH(8)) bus ();

  imem_loader #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .MEM_DEPTH(256)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.fifo_empty = force_empty || (wr_ptr == rd_ptr);

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // FIFO model: a pop presents its word one cycle later
  initial begin
    rd_ptr = 0;
    bus.fifo_rdata = '0;
    forever begin
      @(posedge clk);
      if (flush) begin
        rd_ptr <= wr_ptr;
      end else if (bus.fifo_rd_en) begin
        bus.fifo_rdata <= fifo_mem[rd_ptr[7:0]];
        rd_ptr <= rd_ptr + 1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every write must match the oldest expected write
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.we) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_write_dir", {24'd0, bus.dir}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          checkOutput("write_dir", {24'd0, bus.dir}, {24'd0, e.dir});
          checkOutput("write_data", bus.data_in, e.data);
        end
      end
    end
  end

  task automatic pushWord(input logic [31:0] data, input logic [7:0] dir, input bit expect_write);
    wr_t e;
    fifo_mem[wr_ptr[7:0]] = data;
    wr_ptr = wr_ptr + 1;
    if (expect_write) begin
      e.dir  = dir;
      e.data = data;
      exp_q.push_back(e);
    end
  endtask

  task automatic applyStimulus(input logic [6:0] l);
    @(negedge clk);
    bus.start = 1'b1;
    bus.len   = l;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic checkZero(input string tag);
    checkOutput({tag, "_rd_en"}, {31'd0, bus.fifo_rd_en}, 32'd0);
    checkOutput({tag, "_we"}, {31'd0, bus.we}, 32'd0);
    checkOutput({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    checkOutput({tag, "_done"}, {31'd0, bus.done}, 32'd0);
    checkOutput({tag, "_cpu_hold"}, {31'd0, bus.cpu_hold}, 32'd0);
    checkOutput({tag, "_dir"}, {24'd0, bus.dir}, 32'd0);
    checkOutput({tag, "_data_in"}, bus.data_in, 32'd0);
  endtask

  // Waits for done; exp_cycles>0 checks its cycle position, inject_at>0 issues a stray start
  task automatic waitDone(input string tag, input int exp_cycles, input int inject_at, input int exp_pops);
    int n;
    int p0;
    bit got;
    n = 0;
    got = 0;
    p0 = rd_ptr;
    while (n < 2000 && !got) begin
      @(negedge clk);
      n++;
      if (n == inject_at) begin
        bus.start = 1'b1;
        bus.len   = 7'd2;
      end else if (n == inject_at + 1) begin
        bus.start = 1'b0;
      end
      if (bus.done) got = 1;
    end
    if (!got) begin
      checkOutput({tag, "_done_timeout"}, 32'd0, 32'd1);
    end else if (exp_cycles > 0) begin
      checkOutput({tag, "_done_cycle"}, n, exp_cycles);
    end
    checkOutput({tag, "_pops"}, rd_ptr - p0, exp_pops + (p0 - p0));
    @(negedge clk);
    checkOutput({tag, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
    checkOutput({tag, "_busy_after"}, {31'd0, bus.busy}, 32'd0);
    checkOutput({tag, "_pending_writes"}, exp_q.size(), 32'd0);
  endtask

  // Directed test sequence
  initial begin
    int n;
    int wcnt;
    total = 0;
    bad = 0;
    wr_ptr = 0;
    rst_n = 1'b0;
    force_empty = 1'b0;
    flush = 1'b0;
    bus.start = 1'b0;
    bus.len = '0;
    #1;
    checkZero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] three-word load");
    pushWord(32'h00A00093, 8'h00, 1);
    pushWord(32'h00100113, 8'h04, 1);
    pushWord(32'h002081B3, 8'h08, 1);
    applyStimulus(7'd3);
    waitDone("len3", 10, -10, 3);

    $display("[TB] zero-length load");
    applyStimulus(7'd0);
    waitDone("len0", 1, -10, 0);

    $display("[TB] oversize load clipped");
    for (int i = 0; i < 70; i++) begin
      pushWord(32'h1000_0000 + i, 8'(4 * i), i < 64);
    end
    applyStimulus(7'd100);
    waitDone("len100", 193, -10, 64);
    checkOutput("len100_fifo_left", wr_ptr - rd_ptr, 32'd6);
    checkOutput("len100_last_dir", {24'd0, bus.dir}, 32'hFC);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    @(negedge clk);

    $display("[TB] stalled FIFO");
    pushWord(32'hAAAA_0001, 8'h00, 1);
    pushWord(32'hAAAA_0002, 8'h04, 1);
    pushWord(32'hAAAA_0003, 8'h08, 1);
    applyStimulus(7'd3);
    n = 0;
    while (n < 50 && !bus.we) begin
      @(negedge clk);
      n++;
    end
    checkOutput("stall_first_write_seen", {31'd0, bus.we}, 32'd1);
    force_empty = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("stall_rd_en", {31'd0, bus.fifo_rd_en}, 32'd0);
      checkOutput("stall_we", {31'd0, bus.we}, 32'd0);
      checkOutput("stall_cpu_hold", {31'd0, bus.cpu_hold}, 32'd1);
    end
    force_empty = 1'b0;
    waitDone("stall", 0, -10, 2);

    $display("[TB] start while busy");
    pushWord(32'hBBBB_0001, 8'h00, 1);
    pushWord(32'hBBBB_0002, 8'h04, 1);
    pushWord(32'hBBBB_0003, 8'h08, 1);
    pushWord(32'hBBBB_0004, 8'h0C, 1);
    applyStimulus(7'd4);
    waitDone("busy_start", 13, 5, 4);

    $display("[TB] reset mid-load");
    pushWord(32'hCCCC_0001, 8'h00, 1);
    pushWord(32'hCCCC_0002, 8'h04, 1);
    applyStimulus(7'd5);
    n = 0;
    wcnt = 0;
    while (n < 100 && wcnt < 2) begin
      @(negedge clk);
      n++;
      if (bus.we) wcnt++;
    end
    checkOutput("rst_two_writes", wcnt, 32'd2);
    repeat (2) @(negedge clk);
    checkOutput("rst_busy_before", {31'd0, bus.busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkZero("midreset");
    repeat (2) @(negedge clk);
    checkZero("midreset_hold");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkZero("after_release");
    pushWord(32'hDDDD_0001, 8'h00, 1);
    applyStimulus(7'd1);
    waitDone("post_reset", 4, -10, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit so the bench always terminates
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, instruction word width.
REQ-002 Parameter: BYTE_WIDTH, default 8, width of instruction-memory write address (dir).
REQ-003 Parameter: MEM_DEPTH, default 256, instruction-memory depth in bytes; word capacity MAX_WORDS = MEM_DEPTH/4 = 64.
REQ-004 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-005 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-006 Port: start  input  1  single-cycle request to begin a load.
REQ-007 Port: len  input  7  number of words to load; sampled only on accepted start.
REQ-008 Port: fifo_empty  input  1  upstream FIFO has no data.
REQ-009 Port: fifo_rdata  input  DATA_WIDTH  FIFO read data, valid one cycle after fifo_rd_en.
REQ-010 Port: fifo_rd_en  output  1  FIFO pop request.
REQ-011 Port: data_in  output  DATA_WIDTH  instruction word to instruction memory.
REQ-012 Port: dir  output  BYTE_WIDTH  byte address of word being written.
REQ-013 Port: we  output  1  instruction-memory write enable.
REQ-014 Port: busy  output  1  high whenever state is not IDLE.
REQ-015 Port: done  output  1  one-cycle pulse at load completion.
REQ-016 Port: cpu_hold  output  1  holds processor stalled while busy; equals busy.

Function
REQ-017 FSM states SHALL be IDLE, REQ, WAIT, WRITE, DONE.
REQ-018 IDLE: start=1 and len!=0 -> REQ; latch len (saturated), clear word counter and address register to 0.
REQ-019 IDLE: start=1 and len=0 -> DONE directly; no FIFO pop, no write.
REQ-020 len > MAX_WORDS SHALL be saturated to MAX_WORDS (64); no write beyond byte address 252.
REQ-021 REQ: fifo_rd_en = 1 combinationally iff fifo_empty=0; on that cycle -> WAIT; if fifo_empty=1 stay in REQ with fifo_rd_en=0 (stall, no timeout).
REQ-022 fifo_rd_en SHALL be 0 in every state other than REQ.
REQ-023 WAIT: capture fifo_rdata into data register -> WRITE; exactly one cycle.
REQ-024 WRITE: we=1 for exactly one cycle, dir = address register, data_in = captured word.
REQ-025 On leaving WRITE: address += 4 (BYTE_WIDTH-bit), counter += 1; if counter reaches latched len -> DONE, else -> REQ.
REQ-026 Addresses written SHALL be 0, 4, 8, ... 4*(len-1), word-aligned, strictly increasing; no wrap occurs due to REQ-020.
REQ-027 DONE: done=1 for one cycle -> IDLE.
REQ-028 we, dir, data_in SHALL be driven from state/registers only (no combinational path from FIFO inputs).
REQ-029 start while busy=1 SHALL be ignored; latched len unchanged.
REQ-030 Throughput with non-empty FIFO: 3 cycles per word; load of N words completes (done high) 3N+1 cycles after start accepted.
REQ-031 dir and data_in SHALL hold last written values outside WRITE; only we qualifies them.

Reset
REQ-032 rst_n=0 SHALL asynchronously force state IDLE, counter=0, address=0, data register=0.
REQ-033 During reset: fifo_rd_en=0, we=0, busy=0, done=0, cpu_hold=0, dir=0, data_in=0.
REQ-034 Reset mid-load SHALL abort without further writes or pops; after release, block waits in IDLE for new start.

Verification
REQ-035 Load 3 words 0x00A00093, 0x00100113, 0x002081B3, FIFO always non-empty, len=3 -> we pulses at dir 0x00, 0x04, 0x08 with those words, done one cycle at 10th cycle after start, busy low after.
REQ-036 len=0 with start -> no fifo_rd_en, no we, done pulses one cycle later.
REQ-037 len=100 with 64+ words in FIFO -> exactly 64 writes, last at dir 0xFC, then done; remaining FIFO entries untouched.
REQ-038 FIFO empty for 5 cycles after 1st word -> FSM holds in REQ, fifo_rd_en=0, we=0, cpu_hold=1; resumes and writes word 2 at dir 0x04.
REQ-039 start asserted during load of len=4 with len=2 on input -> ignored; still 4 writes.
REQ-040 rst_n pulsed low after 2nd write of len=5 -> all outputs 0 immediately, no further we; new start with len=1 writes at dir 0x00.
